// File: rtl/vga_mem_rd_arbiter_if.sv
// vga_mem_rd_arbiter_if
// Groups every signal between the arbiter and its environment. The
// environment is two AXI4 read masters and one memory-controller read port.
//   p0_* : display scanline fetcher (real-time) AR/R channel
//   p1_* : blitter / CPU DMA (best-effort) AR/R channel
//   mem_*: shared 128-bit memory-controller AR/R channel
//   rid_err: sticky error flag from the arbiter
// modport slave  : the arbiter's view. It serves p0/p1 and masters mem.
// modport master : the environment's view (requesters plus memory model).
interface vga_mem_rd_arbiter_if;
  logic [26:0]  p0_araddr,  p1_araddr;
  logic [7:0]   p0_arlen,   p1_arlen;
  logic         p0_arvalid, p1_arvalid;
  logic         p0_arready, p1_arready;
  logic [127:0] p0_rdata,   p1_rdata;
  logic [1:0]   p0_rresp,   p1_rresp;
  logic         p0_rlast,   p1_rlast;
  logic         p0_rvalid,  p1_rvalid;
  logic         p0_rready,  p1_rready;

  logic [3:0]   mem_arid;
  logic [26:0]  mem_araddr;
  logic [7:0]   mem_arlen;
  logic [2:0]   mem_arsize;
  logic [1:0]   mem_arburst;
  logic         mem_arlock;
  logic         mem_arvalid;
  logic         mem_arready;
  logic [3:0]   mem_rid;
  logic [127:0] mem_rdata;
  logic [1:0]   mem_rresp;
  logic         mem_rlast;
  logic         mem_rvalid;
  logic         mem_rready;

  logic         rid_err;

  modport slave (
    input  p0_araddr, p1_araddr, p0_arlen, p1_arlen, p0_arvalid, p1_arvalid,
    output p0_arready, p1_arready,
    output p0_rdata, p1_rdata, p0_rresp, p1_rresp, p0_rlast, p1_rlast,
    output p0_rvalid, p1_rvalid,
    input  p0_rready, p1_rready,
    output mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arburst,
    output mem_arlock, mem_arvalid,
    input  mem_arready,
    input  mem_rid, mem_rdata, mem_rresp, mem_rlast, mem_rvalid,
    output mem_rready,
    output rid_err
  );

  modport master (
    output p0_araddr, p1_araddr, p0_arlen, p1_arlen, p0_arvalid, p1_arvalid,
    input  p0_arready, p1_arready,
    input  p0_rdata, p1_rdata, p0_rresp, p1_rresp, p0_rlast, p1_rlast,
    input  p0_rvalid, p1_rvalid,
    output p0_rready, p1_rready,
    input  mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arburst,
    input  mem_arlock, mem_arvalid,
    output mem_arready,
    output mem_rid, mem_rdata, mem_rresp, mem_rlast, mem_rvalid,
    input  mem_rready,
    input  rid_err
  );
endinterface

// File: rtl/vga_mem_rd_arbiter.sv
// vga_mem_rd_arbiter
// Two-port AXI4 read arbiter onto one memory-controller read port.
// Port 0 (display) has priority. Port 1 is guaranteed a grant after at most
// STARVE_LIMIT consecutive port-0 grants while it waits. Accepted bursts are
// counted per port until their rlast returns, and the total is capped at
// MAX_OUTSTANDING. R beats are routed back by mem_rid.
// Ports:
//   mem_clk   : clock
//   mem_reset : asynchronous active-high reset
//   bus       : vga_mem_rd_arbiter_if.slave (p0/p1 AR+R, mem AR+R, rid_err)
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no AR held, mem_arvalid=0
// S_FULL  | AR held for memory, fields stable until arready
module vga_mem_rd_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                  mem_clk,
  input  logic                  mem_reset,
  vga_mem_rd_arbiter_if.slave   bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t        state_q;
  logic [3:0]    arid_q;
  logic [26:0]   araddr_q;
  logic [7:0]    arlen_q;
  logic [CW-1:0] cnt0_q, cnt1_q, cnt0_d, cnt1_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;

  logic          r_hs, last_hs, dec0, dec1, bad_rid, underflow;
  logic [CW:0]   total_eff;
  logic          cap_ok, gnt0, gnt1;

  // R routing: zero-latency, selected by mem_rid.
  always_comb begin
    bus.p0_rvalid  = 1'b0;
    bus.p1_rvalid  = 1'b0;
    bus.mem_rready = 1'b1;
    bad_rid        = 1'b0;
    case (bus.mem_rid)
      4'd0: begin
        bus.p0_rvalid  = bus.mem_rvalid;
        bus.mem_rready = bus.p0_rready;
      end
      4'd1: begin
        bus.p1_rvalid  = bus.mem_rvalid;
        bus.mem_rready = bus.p1_rready;
      end
      default: bad_rid = bus.mem_rvalid;
    endcase
  end

  assign bus.p0_rdata = bus.mem_rdata;
  assign bus.p1_rdata = bus.mem_rdata;
  assign bus.p0_rresp = bus.mem_rresp;
  assign bus.p1_rresp = bus.mem_rresp;
  assign bus.p0_rlast = bus.mem_rlast;
  assign bus.p1_rlast = bus.mem_rlast;

  assign r_hs      = bus.mem_rvalid & bus.mem_rready;
  assign last_hs   = r_hs & bus.mem_rlast;
  assign dec0      = last_hs & (bus.mem_rid == 4'd0) & (cnt0_q != '0);
  assign dec1      = last_hs & (bus.mem_rid == 4'd1) & (cnt1_q != '0);
  assign underflow = last_hs & (((bus.mem_rid == 4'd0) & (cnt0_q == '0)) |
                                ((bus.mem_rid == 4'd1) & (cnt1_q == '0)));

  // A burst completing this cycle frees its credit for a capture in the
  // same cycle, so the cap check uses the post-decrement total.
  assign total_eff = {1'b0, cnt0_q} + {1'b0, cnt1_q}
                   - {{CW{1'b0}}, dec0} - {{CW{1'b0}}, dec1};

  assign cap_ok = ((state_q == S_EMPTY) | bus.mem_arready) &
                  (total_eff < (CW+1)'(MAX_OUTSTANDING));
  assign gnt0   = cap_ok & bus.p0_arvalid &
                  ~(bus.p1_arvalid & (starve_q == SW'(STARVE_LIMIT)));
  assign gnt1   = cap_ok & bus.p1_arvalid & ~gnt0;

  assign bus.p0_arready = gnt0;
  assign bus.p1_arready = gnt1;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    case ({gnt0, dec0})
      2'b10:   cnt0_d = cnt0_q + 1'b1;
      2'b01:   cnt0_d = cnt0_q - 1'b1;
      default: cnt0_d = cnt0_q;
    endcase
    case ({gnt1, dec1})
      2'b10:   cnt1_d = cnt1_q + 1'b1;
      2'b01:   cnt1_d = cnt1_q - 1'b1;
      default: cnt1_d = cnt1_q;
    endcase

    starve_d = starve_q;
    if (gnt1 | ~bus.p1_arvalid)
      starve_d = '0;
    else if (gnt0 && (starve_q != SW'(STARVE_LIMIT)))
      starve_d = starve_q + 1'b1;

    err_d = err_q | bad_rid | underflow;
  end

  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state_q  <= S_EMPTY;
      arid_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      starve_q <= starve_d;
      err_q    <= err_d;
      if (gnt0 | gnt1) begin
        state_q  <= S_FULL;
        arid_q   <= {3'b000, gnt1};
        araddr_q <= gnt1 ? bus.p1_araddr : bus.p0_araddr;
        arlen_q  <= gnt1 ? bus.p1_arlen  : bus.p0_arlen;
      end else if (bus.mem_arready) begin
        state_q <= S_EMPTY;
      end
    end
  end

  assign bus.mem_arvalid = (state_q == S_FULL);
  assign bus.mem_arid    = arid_q;
  assign bus.mem_araddr  = araddr_q;
  assign bus.mem_arlen   = arlen_q;
  assign bus.mem_arsize  = 3'b100;
  assign bus.mem_arburst = 2'b01;
  assign bus.mem_arlock  = 1'b0;
  assign bus.rid_err     = err_q;

endmodule

// File: tb/tb_vga_mem_rd_arbiter.sv
module tb_vga_mem_rd_arbiter;
  logic mem_clk = 1'b0;
  logic mem_reset;
  int   n_total = 0;
  int   n_pass  = 0;

  vga_mem_rd_arbiter_if bus ();

  vga_mem_rd_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .mem_clk   (mem_clk),
    .mem_reset (mem_reset),
    .bus       (bus)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic [3:0] rid;
    logic       rvalid;
    logic       p0_rr;
    logic       p1_rr;
    logic       e_p0v;
    logic       e_p1v;
    logic       e_mrr;
    logic       e_err;
  } rvec_t;

  rvec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.p0_arvalid  = 0; bus.p1_arvalid = 0;
    bus.p0_araddr   = 0; bus.p1_araddr  = 0;
    bus.p0_arlen    = 0; bus.p1_arlen   = 0;
    bus.p0_rready   = 0; bus.p1_rready  = 0;
    bus.mem_arready = 0;
    bus.mem_rid     = 0; bus.mem_rdata  = 0; bus.mem_rresp = 0;
    bus.mem_rlast   = 0; bus.mem_rvalid = 0;
  endtask

  // Called right after a posedge; the pulse ends clear of both edges.
  task automatic do_reset();
    idle_inputs();
    mem_reset = 1;
    #3;
    mem_reset = 0;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"},  32'(bus.mem_arvalid), 0);
    chk({tag, "_arid"},     32'(bus.mem_arid),    0);
    chk({tag, "_araddr"},   32'(bus.mem_araddr),  0);
    chk({tag, "_arlen"},    32'(bus.mem_arlen),   0);
    chk({tag, "_arsize"},   32'(bus.mem_arsize),  4);
    chk({tag, "_arburst"},  32'(bus.mem_arburst), 1);
    chk({tag, "_arlock"},   32'(bus.mem_arlock),  0);
    chk({tag, "_p0arrdy"},  32'(bus.p0_arready),  0);
    chk({tag, "_p1arrdy"},  32'(bus.p1_arready),  0);
    chk({tag, "_rid_err"},  32'(bus.rid_err),     0);
    chk({tag, "_cnt0"},     32'(dut.cnt0_q),      0);
    chk({tag, "_cnt1"},     32'(dut.cnt1_q),      0);
  endtask

  initial begin
    logic exp1;
    logic prev;

    //        rid   rv  p0rr p1rr  p0v p1v mrr err
    vt[0] = '{4'd0, 1, 1, 0, 1, 0, 1, 0};
    vt[1] = '{4'd0, 1, 0, 1, 1, 0, 0, 0};
    vt[2] = '{4'd1, 1, 0, 1, 0, 1, 1, 0};
    vt[3] = '{4'd1, 1, 1, 0, 0, 1, 0, 0};
    vt[4] = '{4'd0, 0, 1, 1, 0, 0, 1, 0};
    vt[5] = '{4'd1, 0, 0, 0, 0, 0, 0, 0};
    vt[6] = '{4'd3, 0, 0, 0, 0, 0, 1, 0};
    vt[7] = '{4'd6, 1, 0, 0, 0, 0, 1, 1};

    idle_inputs();
    mem_reset = 1;
    #12;
    chk_reset_outputs("rst");
    chk("rst_p0rvalid", 32'(bus.p0_rvalid), 0);
    chk("rst_mrready",  32'(bus.mem_rready), 0);
    tick();
    mem_reset = 0;
    tick();

    // R routing vectors, rlast low so counters are untouched.
    for (int i = 0; i < 8; i++) begin
      bus.mem_rid    = vt[i].rid;
      bus.mem_rvalid = vt[i].rvalid;
      bus.p0_rready  = vt[i].p0_rr;
      bus.p1_rready  = vt[i].p1_rr;
      bus.mem_rdata  = {96'h0, 32'hA5A50000 + 32'(i)};
      bus.mem_rresp  = 2'(i);
      #2;
      chk($sformatf("tbl%0d_p0rvalid", i), 32'(bus.p0_rvalid),  32'(vt[i].e_p0v));
      chk($sformatf("tbl%0d_p1rvalid", i), 32'(bus.p1_rvalid),  32'(vt[i].e_p1v));
      chk($sformatf("tbl%0d_mrready",  i), 32'(bus.mem_rready), 32'(vt[i].e_mrr));
      chk($sformatf("tbl%0d_p1rdata",  i), bus.p1_rdata[31:0],  32'hA5A50000 + 32'(i));
      chk($sformatf("tbl%0d_p0rresp",  i), 32'(bus.p0_rresp),   32'(i % 4));
      tick();
      chk($sformatf("tbl%0d_rid_err",  i), 32'(bus.rid_err),    32'(vt[i].e_err));
    end
    do_reset();
    tick();

    // Single request from p0.
    bus.p0_arvalid = 1; bus.p0_araddr = 27'h100; bus.p0_arlen = 8'd4;
    #2;
    chk("s1_p0arready", 32'(bus.p0_arready), 1);
    chk("s1_p1arready", 32'(bus.p1_arready), 0);
    chk("s1_arvalid_pre", 32'(bus.mem_arvalid), 0);
    tick();
    bus.p0_arvalid = 0;
    chk("s1_arvalid", 32'(bus.mem_arvalid), 1);
    chk("s1_arid",    32'(bus.mem_arid),    0);
    chk("s1_araddr",  32'(bus.mem_araddr),  32'h100);
    chk("s1_arlen",   32'(bus.mem_arlen),   4);
    chk("s1_arsize",  32'(bus.mem_arsize),  4);
    chk("s1_cnt0",    32'(dut.cnt0_q),      1);
    bus.mem_arready = 1;
    tick();
    bus.mem_arready = 0;
    chk("s1_arvalid_drop", 32'(bus.mem_arvalid), 0);
    bus.p0_rready = 1; bus.p1_rready = 1;
    for (int b = 0; b < 5; b++) begin
      bus.mem_rvalid = 1; bus.mem_rid = 0; bus.mem_rlast = (b == 4);
      bus.mem_rdata = {32'hDEAD0000 + 32'(b), 96'h0};
      #2;
      chk($sformatf("s1_b%0d_p0rvalid", b), 32'(bus.p0_rvalid), 1);
      chk($sformatf("s1_b%0d_p1rvalid", b), 32'(bus.p1_rvalid), 0);
      chk($sformatf("s1_b%0d_p0rdata", b), bus.p0_rdata[127:96], 32'hDEAD0000 + 32'(b));
      chk($sformatf("s1_b%0d_p0rlast", b), 32'(bus.p0_rlast), 32'(b == 4));
      chk($sformatf("s1_b%0d_cnt0", b), 32'(dut.cnt0_q), 1);
      tick();
    end
    bus.mem_rvalid = 0; bus.mem_rlast = 0;
    chk("s1_cnt0_done", 32'(dut.cnt0_q), 0);
    chk("s1_rid_err",   32'(bus.rid_err), 0);

    // Contention: grant pattern 8 x p0 then 1 x p1. Each cycle returns the
    // rlast of the previous grant so the outstanding cap never binds.
    do_reset();
    tick();
    bus.p0_arvalid = 1; bus.p0_araddr = 27'h10; bus.p0_arlen = 8'd1;
    bus.p1_arvalid = 1; bus.p1_araddr = 27'h20; bus.p1_arlen = 8'd2;
    bus.mem_arready = 1; bus.p0_rready = 1; bus.p1_rready = 1;
    prev = 0;
    for (int i = 0; i < 27; i++) begin
      exp1 = ((i % 9) == 8);
      #2;
      chk($sformatf("ct%0d_p0arready", i), 32'(bus.p0_arready), 32'(!exp1));
      chk($sformatf("ct%0d_p1arready", i), 32'(bus.p1_arready), 32'(exp1));
      if (i > 0)
        chk($sformatf("ct%0d_p%0d_rvalid", i, prev),
            32'(prev ? bus.p1_rvalid : bus.p0_rvalid), 1);
      tick();
      chk($sformatf("ct%0d_arid", i),   32'(bus.mem_arid),   32'(exp1));
      chk($sformatf("ct%0d_araddr", i), 32'(bus.mem_araddr), exp1 ? 32'h20 : 32'h10);
      bus.mem_rvalid = 1; bus.mem_rlast = 1; bus.mem_rid = {3'b000, exp1};
      prev = exp1;
    end
    bus.p0_arvalid = 0; bus.p1_arvalid = 0;
    tick();
    bus.mem_rvalid = 0;
    chk("ct_rid_err", 32'(bus.rid_err), 0);

    // Outstanding cap: 4 accepted, 5th held until a same-cycle rlast.
    do_reset();
    tick();
    bus.p0_arvalid = 1; bus.p0_araddr = 27'h40; bus.mem_arready = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("cap%0d_p0arready", i), 32'(bus.p0_arready), 1);
      tick();
    end
    chk("cap_cnt0", 32'(dut.cnt0_q), 4);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk($sformatf("cap_hold%0d", i), 32'(bus.p0_arready), 0);
      tick();
    end
    bus.p0_rready = 1; bus.mem_rvalid = 1; bus.mem_rid = 0; bus.mem_rlast = 1;
    #2;
    chk("cap_admit", 32'(bus.p0_arready), 1);
    tick();
    bus.mem_rvalid = 0; bus.mem_rlast = 0; bus.p0_arvalid = 0;
    chk("cap_cnt0_net", 32'(dut.cnt0_q), 4);

    // Backpressure: slot held 10 cycles, then p1 captured on arready rise.
    do_reset();
    tick();
    bus.p0_arvalid = 1; bus.p0_araddr = 27'h200; bus.p0_arlen = 8'd7;
    tick();
    bus.p0_araddr = 27'h300; bus.p0_arlen = 8'd9;
    bus.p1_arvalid = 1; bus.p1_araddr = 27'h400; bus.p1_arlen = 8'd2;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("bp%0d_p0arready", i), 32'(bus.p0_arready), 0);
      chk($sformatf("bp%0d_p1arready", i), 32'(bus.p1_arready), 0);
      chk($sformatf("bp%0d_arvalid", i),   32'(bus.mem_arvalid), 1);
      chk($sformatf("bp%0d_araddr", i),    32'(bus.mem_araddr),  32'h200);
      chk($sformatf("bp%0d_arlen", i),     32'(bus.mem_arlen),   7);
      chk($sformatf("bp%0d_arid", i),      32'(bus.mem_arid),    0);
      tick();
    end
    bus.p0_arvalid = 0; bus.mem_arready = 1;
    #2;
    chk("bp_p1_capture", 32'(bus.p1_arready), 1);
    tick();
    chk("bp_arid",   32'(bus.mem_arid),   1);
    chk("bp_araddr", 32'(bus.mem_araddr), 32'h400);
    chk("bp_arlen",  32'(bus.mem_arlen),  2);
    chk("bp_cnt1",   32'(dut.cnt1_q),     1);

    // p1 capture coinciding with p1 rlast: counter unchanged.
    bus.p1_araddr = 27'h500; bus.p1_rready = 1;
    bus.mem_rvalid = 1; bus.mem_rid = 1; bus.mem_rlast = 1;
    #2;
    chk("sim_p1arready", 32'(bus.p1_arready), 1);
    chk("sim_p1rvalid",  32'(bus.p1_rvalid),  1);
    tick();
    bus.p1_arvalid = 0; bus.mem_arready = 0;
    chk("sim_cnt1", 32'(dut.cnt1_q), 1);
    chk("sim_araddr", 32'(bus.mem_araddr), 32'h500);

    // Unroutable ID.
    bus.p0_rready = 0; bus.p1_rready = 0;
    bus.mem_rid = 4'd5; bus.mem_rlast = 0;
    #2;
    chk("bad_mrready", 32'(bus.mem_rready), 1);
    chk("bad_p0rvalid", 32'(bus.p0_rvalid), 0);
    chk("bad_p1rvalid", 32'(bus.p1_rvalid), 0);
    tick();
    bus.mem_rvalid = 0; bus.mem_rid = 0;
    chk("bad_rid_err", 32'(bus.rid_err), 1);
    tick(); tick();
    chk("bad_rid_err_sticky", 32'(bus.rid_err), 1);

    // Reset mid-burst: two bursts outstanding and the slot FULL.
    chk("mid_cnt_sum", 32'(dut.cnt0_q) + 32'(dut.cnt1_q), 2);
    #2;
    mem_reset = 1;
    #1;
    chk_reset_outputs("mid");
    tick();
    mem_reset = 0;
    tick();
    bus.p0_rready = 1; bus.mem_rvalid = 1; bus.mem_rid = 0; bus.mem_rlast = 1;
    #2;
    chk("mid_p0rvalid", 32'(bus.p0_rvalid), 1);
    tick();
    bus.mem_rvalid = 0; bus.mem_rlast = 0;
    chk("mid_rid_err", 32'(bus.rid_err), 1);
    chk("mid_cnt0",    32'(dut.cnt0_q),  0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule
